bconv_stream: RTL and testbench

BCONV_STREAM -- requirements
Module: bconv_stream

---
 rtl/bconv_stream_if.sv | 29 ++
 rtl/bconv_stream.sv | 147 ++++++++++++++
 tb/tb_bconv_stream.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bconv_stream_if.sv
// Streaming binary-conv handshake bundle: weight strobe, pixel in, result beats out.
// master drives pixels, weights and out_ready; slave is the convolution engine.
interface bconv_stream_if #(
  parameter int DW  = 8,
  parameter int NCH = 1,
  parameter int OW  = 32
);
  logic              weight_en;
  logic              weight;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     din;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*OW-1:0] dout;
  logic              out_last;
  logic              done;
  logic              wload_done;

  modport master (
    output weight_en, weight, in_valid, din, out_ready,
    input  in_ready, out_valid, dout, out_last, done, wload_done
  );

  modport slave (
    input  weight_en, weight, in_valid, din, out_ready,
    output in_ready, out_valid, dout, out_last, done, wload_done
  );
endinterface

// File: rtl/bconv_stream.sv
// KxK binary-weight convolution over a raster pixel stream; results 2 advancing cycles after the completing pixel.
// A stalled output beat freezes the whole pipeline and drops in_ready.
module bconv_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int NCH   = 1,
  parameter int OW    = 32
) (
  input logic           clk,
  input logic           rst,
  bconv_stream_if.slave io
);
  localparam int NW  = NCH * K * K;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0]  C_MAX  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  C_WIN  = CW'(K - 1);
  localparam logic [RW-1:0]  R_MAX  = RW'(IMG_H - 1);
  localparam logic [RW-1:0]  R_WIN  = RW'(K - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(NW - 1);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                  state;
  logic [NW-1:0]           wbits;
  logic [WCW-1:0]          wcnt;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [DW-1:0]           lb  [K-1][IMG_W];
  logic [DW-1:0]           win [K][K];
  logic                    win_vld, win_last, s1_vld, s1_last;
  logic signed [OW-1:0]    rsum     [NCH][K];
  logic signed [OW-1:0]    rsum_nxt [NCH][K];
  logic signed [OW-1:0]    acc, pix, tot;
  logic [NCH*OW-1:0]       dsum;
  logic                    adv, accept, idle, win_done, frame_end;

  assign adv         = !(io.out_valid && !io.out_ready);
  assign io.in_ready = (state == S_RUN) && adv;
  assign accept      = io.in_valid && io.in_ready;
  assign win_done    = (row >= R_WIN) && (col >= C_WIN);
  assign frame_end   = (row == R_MAX) && (col == C_MAX);
  assign idle        = (row == '0) && (col == '0) && !win_vld && !s1_vld && !io.out_valid;
  assign io.done     = io.out_valid && io.out_ready && io.out_last;

  // Weight reload is only honoured between frames with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOAD;
      wcnt          <= '0;
      wbits         <= '0;
      io.wload_done <= 1'b0;
    end else begin
      case (state)
        S_LOAD: if (io.weight_en) begin
          wbits[wcnt] <= io.weight;
          if (wcnt == W_LAST) begin
            wcnt          <= '0;
            state         <= S_RUN;
            io.wload_done <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_RUN: if (io.weight_en && idle) begin
          wbits[0]      <= io.weight;
          wcnt          <= WCW'(1);
          state         <= S_LOAD;
          io.wload_done <= 1'b0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      win_vld      <= 1'b0;
      win_last     <= 1'b0;
      s1_vld       <= 1'b0;
      s1_last      <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
      io.dout      <= '0;
    end else if (adv) begin
      if (accept) begin
        if (col == C_MAX) begin
          col <= '0;
          row <= (row == R_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      win_vld      <= accept && win_done;
      win_last     <= accept && win_done && frame_end;
      s1_vld       <= win_vld;
      s1_last      <= win_last;
      io.out_valid <= s1_vld;
      io.out_last  <= s1_last;
      io.dout      <= dsum;
    end
  end

  // Line buffers hold the K-1 previous rows; the window shifts one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 2; i++) lb[i][col] <= lb[i+1][col];
      lb[K-2][col] <= io.din;
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K - 1; kc++) win[kr][kc] <= win[kr][kc+1];
      for (int kr = 0; kr < K - 1; kr++) win[kr][K-1] <= lb[kr][col];
      win[K-1][K-1] <= io.din;
    end
    if (adv) rsum <= rsum_nxt;
  end

  always_comb begin
    acc = '0;
    pix = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int kr = 0; kr < K; kr++) begin
        acc = '0;
        for (int kc = 0; kc < K; kc++) begin
          pix = OW'(win[kr][kc]);
          if (wbits[ch*K*K + kr*K + kc]) acc = acc + pix;
          else                           acc = acc - pix;
        end
        rsum_nxt[ch][kr] = acc;
      end
    end
  end

  always_comb begin
    dsum = '0;
    tot  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      tot = '0;
      for (int kr = 0; kr < K; kr++) tot = tot + rsum[ch][kr];
      dsum[ch*OW +: OW] = tot;
    end
  end
endmodule

// File: tb/tb_bconv_stream.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_bconv_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bconv_stream_if #(.DW(8), .NCH(1), .OW(32)) ifa ();
  bconv_stream_if #(.DW(8), .NCH(2), .OW(32)) ifb ();

  bconv_stream #(.DW(8), .IMG_W(28), .IMG_H(28), .K(5), .NCH(1), .OW(32)) dut_a (
    .clk(clk), .rst(rst), .io(ifa.slave));
  bconv_stream #(.DW(8), .IMG_W(28), .IMG_H(28), .K(5), .NCH(2), .OW(32)) dut_b (
    .clk(clk), .rst(rst), .io(ifb.slave));

  typedef struct {longint val; bit last;} exp_t;

  exp_t        q_a[$];
  bit          q_b[$];
  int          checks = 0;
  int          passes = 0;
  int          beats_a = 0, dones_a = 0, beats_b = 0, dones_b = 0;
  int          cyc = 0;
  bit          stall_mode = 1'b0;
  logic [24:0] wa = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: event not seen / not expected", name);
  endtask

  function automatic int pixval(input int mode, input int r, input int c);
    if (mode == 0) return 1;
    if (mode == 1) return 255;
    return (r * 28 + c) % 256;
  endfunction

  function automatic longint gold(input int r, input int c);
    longint s = 0;
    for (int kr = 0; kr < 5; kr++)
      for (int kc = 0; kc < 5; kc++) begin
        longint p = longint'(pixval(2, r - 4 + kr, c - 4 + kc));
        s = wa[kr*5 + kc] ? s + p : s - p;
      end
    return s;
  endfunction

  // out_ready is high 1 of every 3 cycles in stall mode.
  initial begin
    ifa.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ifa.out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifa.out_valid) begin
      if (q_a.size() == 0) fail("a_extra_beat");
      else if (ifa.out_ready) begin
        e = q_a.pop_front();
        check("a_dout", longint'($signed(ifa.dout)), e.val);
        check("a_last", ifa.out_last, e.last);
        check("a_done_pulse", ifa.done, e.last);
        beats_a++;
      end else begin
        check("a_stall_dout", longint'($signed(ifa.dout)), q_a[0].val);
        check("a_stall_in_ready", ifa.in_ready, 0);
      end
    end
    if (!rst && ifa.done) dones_a++;
  end

  always @(negedge clk) begin
    bit l;
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (q_b.size() == 0) fail("b_extra_beat");
      else begin
        l = q_b.pop_front();
        check("b_ch0", longint'($signed(ifb.dout[31:0])), 25);
        check("b_ch1", longint'($signed(ifb.dout[63:32])), -25);
        check("b_last", ifb.out_last, l);
        beats_b++;
      end
    end
    if (!rst && ifb.done) dones_b++;
  end

  task automatic load_a(input logic [24:0] w);
    for (int j = 0; j < 25; j++) begin
      ifa.weight_en = 1'b1;
      ifa.weight    = w[j];
      @(posedge clk);
      #1;
      if (j == 0) begin
        check("a_wload_low", ifa.wload_done, 0);
        check("a_load_in_ready", ifa.in_ready, 0);
      end
    end
    ifa.weight_en = 1'b0;
    check("a_wload_done", ifa.wload_done, 1);
    wa = w;
  endtask

  task automatic frame_a(input int mode, input int npix, input bit use_fixed, input longint fixed);
    for (int i = 0; i < npix; i++) begin
      int   r, c, t;
      bit   acc;
      exp_t e;
      r = (i / 28) % 28;
      c = i % 28;
      ifa.din      = 8'(pixval(mode, r, c));
      ifa.in_valid = 1'b1;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = ifa.in_ready;
        if (acc && r >= 4 && c >= 4) begin
          e.val  = use_fixed ? fixed : gold(r, c);
          e.last = (r == 27 && c == 27);
          q_a.push_back(e);
        end
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        fail("a_in_ready_timeout");
        break;
      end
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic drain_a(input int exp_beats);
    int t = 0;
    while (q_a.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("a_drain", q_a.size(), 0);
    check("a_beats", beats_a, exp_beats);
    check("a_done_count", dones_a, 1);
    beats_a = 0;
    dones_a = 0;
  endtask

  initial begin
    int t;
    ifa.weight_en = 1'b0; ifa.weight = 1'b0; ifa.in_valid = 1'b0; ifa.din = '0;
    ifb.weight_en = 1'b0; ifb.weight = 1'b0; ifb.in_valid = 1'b0; ifb.din = '0;
    ifb.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ifa.in_ready, 0);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_dout", ifa.dout, 0);
    check("rst_out_last", ifa.out_last, 0);
    check("rst_done", ifa.done, 0);
    check("rst_wload_done", ifa.wload_done, 0);
    check("rst_b_in_ready", ifb.in_ready, 0);
    rst = 1'b0;

    // all-ones weights and pixels
    load_a(25'h1FFFFFF);
    frame_a(0, 784, 1'b1, 25);
    drain_a(576);

    // all -1 weights, saturated pixels
    load_a(25'h0);
    frame_a(1, 784, 1'b1, -6375);
    drain_a(576);

    // ramp image, random weights
    load_a(25'($urandom));
    frame_a(2, 784, 1'b0, 0);
    drain_a(576);

    // same image under output backpressure, weights retained
    stall_mode = 1'b1;
    frame_a(2, 784, 1'b0, 0);
    drain_a(576);
    stall_mode = 1'b0;

    // reset mid-frame, then full reload
    frame_a(2, 300, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", ifa.out_valid, 0);
    check("midrst_in_ready", ifa.in_ready, 0);
    check("midrst_wload_done", ifa.wload_done, 0);
    q_a.delete();
    rst = 1'b0;
    beats_a = 0;
    dones_a = 0;
    load_a(25'($urandom));
    frame_a(2, 784, 1'b0, 0);
    drain_a(576);

    // two channels, two back-to-back frames
    for (int j = 0; j < 50; j++) begin
      ifb.weight_en = 1'b1;
      ifb.weight    = (j < 25);
      @(posedge clk);
      #1;
    end
    ifb.weight_en = 1'b0;
    check("b_wload_done", ifb.wload_done, 1);
    ifb.din = 8'd1;
    for (int i = 0; i < 1568; i++) begin
      int r, c;
      bit acc;
      r = (i / 28) % 28;
      c = i % 28;
      ifb.in_valid = 1'b1;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = ifb.in_ready;
        if (acc && r >= 4 && c >= 4) q_b.push_back(r == 27 && c == 27);
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        fail("b_in_ready_timeout");
        break;
      end
    end
    ifb.in_valid = 1'b0;
    t = 0;
    while (q_b.size() != 0 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("b_drain", q_b.size(), 0);
    check("b_beats", beats_b, 1152);
    check("b_done_count", dones_b, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
